// File: rtl/detector_scheduler_pkg.sv
// Shared definitions for the detector scheduler: FSM encoding and default sizing.
package det_sched_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_WORD_W = 8;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CLEAR  = 2'b01,
        S_SHIFT  = 2'b10,
        S_REPORT = 2'b11
    } state_t;

endpackage

// File: rtl/detector_scheduler_if.sv
// Request-side bundle between the requesters and the detector scheduler.
interface detector_scheduler_if
    import det_sched_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic [N_REQ-1:0]        req;
    logic [N_REQ*WORD_W-1:0] req_data;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        done;
    logic [CNT_W-1:0]        match_cnt;
    logic                    busy;

    modport master (
        output req, req_data,
        input  grant, done, match_cnt, busy
    );

    modport slave (
        input  req, req_data,
        output grant, done, match_cnt, busy
    );

endinterface

// File: rtl/detector_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic             w_found;
    int               w_pos;
    logic [IDX_W-1:0] w_pos_idx;

    always_comb begin
        o_gnt     = '0;
        o_idx     = '0;
        w_found   = 1'b0;
        w_pos     = 0;
        w_pos_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N_REQ) begin
                w_pos = w_pos - N_REQ;
            end
            w_pos_idx = IDX_W'(w_pos);
            if (!w_found && i_req[w_pos_idx]) begin
                w_found          = 1'b1;
                o_gnt[w_pos_idx] = 1'b1;
                o_idx            = w_pos_idx;
            end
        end
    end

endmodule

// File: rtl/detector_scheduler.sv
// Time-shares one serial Mealy detector among N_REQ requesters: arbitrate,
// clear the detector, shift the granted word MSB-first and report the hit count.
module detector_scheduler
    import det_sched_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    detector_scheduler_if.slave  bus,
    output logic                 det_rst,
    output logic                 det_x,
    input  logic                 det_y
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int BIT_W = $clog2(WORD_W);

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_done;
    logic [CNT_W-1:0]   r_match_cnt;
    logic               r_busy;
    logic               r_det_x;
    logic [WORD_W-1:0]  r_shreg;
    logic [BIT_W-1:0]   r_bitcnt;
    logic [CNT_W-1:0]   r_cnt_acc;

    logic [N_REQ-1:0]   w_gnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_start;
    logic               w_last;
    logic [CNT_W-1:0]   w_cnt_next;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req (bus.req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_start    = |bus.req;
    assign w_last     = (r_bitcnt == BIT_W'(WORD_W - 1));
    // det_y is a Mealy output for the bit currently on det_x, so it is folded in at this edge.
    assign w_cnt_next = r_cnt_acc + CNT_W'(det_y);

    // Control path: FSM and every registered output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_match_cnt <= '0;
            r_busy      <= 1'b0;
            r_det_x     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_CLEAR;
                        r_grant  <= w_gnt;
                        r_busy   <= 1'b1;
                        r_rr_ptr <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
                    end
                end
                S_CLEAR: begin
                    r_state <= S_SHIFT;
                    r_det_x <= r_shreg[WORD_W-1];
                end
                S_SHIFT: begin
                    if (w_last) begin
                        r_state     <= S_REPORT;
                        r_det_x     <= 1'b0;
                        r_done      <= r_grant;
                        r_match_cnt <= w_cnt_next;
                    end else begin
                        r_det_x <= r_shreg[WORD_W-2];
                    end
                end
                S_REPORT: begin
                    r_state <= S_IDLE;
                    r_done  <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath: word shift register and per-job accumulators, re-initialised every job.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    r_shreg <= bus.req_data[w_idx*WORD_W +: WORD_W];
                end
            end
            S_CLEAR: begin
                r_bitcnt  <= '0;
                r_cnt_acc <= '0;
            end
            S_SHIFT: begin
                r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
                r_bitcnt  <= r_bitcnt + BIT_W'(1);
                r_cnt_acc <= w_cnt_next;
            end
            default: begin
            end
        endcase
    end

    assign det_rst       = ~rst | (r_state == S_CLEAR);
    assign det_x         = r_det_x;
    assign bus.grant     = r_grant;
    assign bus.done      = r_done;
    assign bus.match_cnt = r_match_cnt;
    assign bus.busy      = r_busy;

endmodule
